mv_product_feeder: RTL and testbench

- Upstream stage of the adder-accumulator (AAC) in the matrix-vector datapath.
- Accepts signed 8-bit weight/activation pairs over a valid/ready handshake and forms one registered 16-bit product per column.
- Sign-extends each product to the accumulator width and drives the AAC's A_i and aac inputs, zeroing the accumulation on column 0 of each row.
- Counts N_COLS columns per row, then pulses acc_done in the cycle the AAC output holds the completed row sum.

---
 rtl/mvf_pkg.sv | 21 ++
 rtl/mvf_mul_reg.sv | 41 ++++
 rtl/mv_product_feeder.sv | 127 ++++++++++++
 tb/tb_mv_product_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvf_pkg.sv
// mvf_pkg: shared types and defaults for the mv_product_feeder slice.
// Holds the feeder state encoding and the column counter width helper.
package mvf_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int MVF_N_COLS = 128;
  localparam int MVF_DATA_W = 8;
  localparam int MVF_ACC_W  = 24;

  // Column counter width; a single-column row still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvf_mul_reg.sv
// mvf_mul_reg: signed operand multiply, sign-extension to the accumulator
// width, and the product register with its valid bit.
module mvf_mul_reg
  import mvf_pkg::*;
#(
  parameter int DATA_W = MVF_DATA_W,
  parameter int ACC_W  = MVF_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_i,
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] x_i,
  output logic        [ACC_W-1:0]  a_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    prod_q;
  logic                       vld_q;

  assign prod     = w_i * x_i;
  assign prod_ext = ACC_W'(prod);

  // Capture the product of an accepted pair; valid marks a fresh product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= load_i;
      if (load_i) begin
        prod_q <= prod_ext;
      end
    end
  end

  // Bubble cycles present zero so the accumulator value holds.
  assign a_o = vld_q ? prod_q : '0;

endmodule

// File: rtl/mv_product_feeder.sv
// mv_product_feeder: feeds signed products to the adder-accumulator.
// Optional MVF_STALL_CNT_EN adds a saturating RUN-stall counter port.
module mv_product_feeder
  import mvf_pkg::*;
#(
  parameter int N_COLS = MVF_N_COLS,
  parameter int DATA_W = MVF_DATA_W,
  parameter int ACC_W  = MVF_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] x_i,
  output logic        [ACC_W-1:0]  A_o,
  output logic                     aac_o,
  output logic                     busy,
  output logic                     acc_done
`ifdef MVF_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int CNT_W = cnt_width(N_COLS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_COLS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rdy_q;
  logic             busy_q;
  logic             done_q;
  logic             aac_q;
  logic             accept;

  assign accept   = in_valid && rdy_q;
  assign in_ready = rdy_q;
  assign busy     = busy_q;
  assign acc_done = done_q;
  assign aac_o    = aac_q;

  mvf_mul_reg #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept),
    .w_i    (w_i),
    .x_i    (x_i),
    .a_o    (A_o)
  );

  // Row sequencing: column count, handshake and registered AAC control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      aac_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      aac_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          // Column 0 (or a bubble before it) clears; all else accumulates.
          aac_q <= (cnt_q != '0);
          if (accept) begin
            if (cnt_q == LAST) begin
              state_q <= S_FLUSH;
              rdy_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_FLUSH: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          aac_q   <= 1'b1;
        end
        S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef MVF_STALL_CNT_EN
  logic [15:0] stall_q;

  assign stall_cnt = stall_q;

  // Count RUN cycles without offered data, saturating; restart per row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (start &&
                 (state_q == S_IDLE || state_q == S_DONE)) begin
      stall_q <= '0;
    end else if (state_q == S_RUN && !in_valid &&
                 stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mv_product_feeder.sv
// tb_mv_product_feeder: randomized scoreboard bench for mv_product_feeder.
// Models the downstream AAC and checks per-cycle A_o/aac_o and row sums.
module tb_mv_product_feeder;

  localparam int N = 128;

  typedef struct {
    logic [23:0] a;
    logic        aac;
  } exp_t;

  typedef struct {
    longint sum;
    int     done_cyc;
    int     stalls;
  } row_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] w_i;
  logic signed [7:0] x_i;
  logic [23:0]       A_o;
  logic              aac_o;
  logic              busy;
  logic              acc_done;
`ifdef MVF_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  exp_t exp_q[$];
  row_t row_q[$];

  logic [23:0] aac_acc = '0;

  mv_product_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .w_i       (w_i),
    .x_i       (x_i),
    .A_o       (A_o),
    .aac_o     (aac_o),
    .busy      (busy),
    .acc_done  (acc_done)
`ifdef MVF_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream accumulator: aac=0 loads A, aac=1 adds A.
  always @(posedge clk) aac_acc <= aac_o ? aac_acc + A_o : A_o;

  task automatic check(input string name, input longint got,
                       input longint expv);
    total++;
    if (got == expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, got, expv, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per in_ready cycle and one row per done.
  exp_t mon_e;
  row_t mon_r;
  bit   pend = 0;
  bit   prev_done = 0;
  bit   rst_chk = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      row_q.delete();
      pend = 0;
      prev_done = 0;
      if (!rst_chk) begin
        check("rst_A", A_o, 0);
        check("rst_aac", aac_o, 0);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", acc_done, 0);
`ifdef MVF_STALL_CNT_EN
        check("rst_stall", stall_cnt, 0);
`endif
        rst_chk = 1;
      end
    end else begin
      rst_chk = 0;
      if (pend) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL extra_output: no expectation queued (cycle %0d)",
                   cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("A_o", A_o, mon_e.a);
          check("aac_o", aac_o, mon_e.aac);
        end
      end
      if (prev_done) check("done_pulse", acc_done, 0);
      if (acc_done) begin
        if (row_q.size() == 0) begin
          total++;
          $display("FAIL spurious_done: acc_done=1 expected 0 (cycle %0d)",
                   cyc);
        end else begin
          mon_r = row_q.pop_front();
          check("row_sum", aac_acc, mon_r.sum & 64'hFF_FFFF);
          check("done_A", A_o, 0);
          check("done_aac", aac_o, 1);
          check("done_busy", busy, 1);
          if (mon_r.done_cyc >= 0)
            check("done_latency", cyc, mon_r.done_cyc);
`ifdef MVF_STALL_CNT_EN
          check("stall_cnt", stall_cnt, mon_r.stalls);
`endif
        end
      end
      if (!busy) begin
        check("idle_A", A_o, 0);
        check("idle_aac", aac_o, 0);
      end
      pend = in_ready;
      prev_done = acc_done;
    end
  end

  // One row: kind 0 random, 1 ones, 2 -128*-128, 3 -128*127.
  task automatic do_row(input int kind, input int idle_pct,
                        input int force_stalls, input bit b2b,
                        input bit timed);
    int     cols = 0;
    int     guard = 0;
    int     stalls = 0;
    int     wi;
    int     xi;
    int     sc;
    longint sum = 0;
    bit     v;
    bit     prev_stall = 0;
    exp_t   e;
    row_t   r;
    start = 1'b1;
    sc = cyc;
    tick();
    start = 1'b0;
    check("run_entry", in_ready, 1);
`ifdef MVF_STALL_CNT_EN
    check("stall_clr", stall_cnt, 0);
`endif
    while (cols < N && guard < 4 * N) begin
      guard++;
      case (kind)
        1: begin wi = 1; xi = 1; end
        2: begin wi = -128; xi = -128; end
        3: begin wi = -128; xi = 127; end
        default: begin
          wi = int'($urandom_range(0, 255)) - 128;
          xi = int'($urandom_range(0, 255)) - 128;
        end
      endcase
      v = 1'b1;
      if (idle_pct > 0 && int'($urandom_range(0, 99)) < idle_pct)
        v = 1'b0;
      if (force_stalls > 0 && stalls < force_stalls &&
          (cols % 5) == 2 && !prev_stall)
        v = 1'b0;
      prev_stall = !v;
      w_i = 8'(wi);
      x_i = 8'(xi);
      in_valid = v;
      if (in_ready) begin
        e.aac = (cols != 0);
        if (v) begin
          e.a = 24'(wi * xi);
          if (kind == 2) e.a = 24'h004000;
          if (kind == 3) e.a = 24'hFFC080;
          sum += longint'(wi * xi);
          cols++;
        end else begin
          e.a = '0;
          stalls++;
        end
        exp_q.push_back(e);
      end
      tick();
    end
    if (cols < N) begin
      total++;
      $display("FAIL row_budget: accepted %0d required %0d", cols, N);
    end
    in_valid = 1'b0;
    start = b2b;
    r.sum = (kind == 2) ? 64'h20_0000 : sum;
    r.done_cyc = timed ? sc + 130 : -1;
    r.stalls = stalls;
    row_q.push_back(r);
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    w_i = '0;
    x_i = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Abort a row after 50 accepted columns.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      w_i = 8'(i - 25);
      x_i = 8'sd3;
      in_valid = 1'b1;
      if (in_ready) begin
        e.a = 24'((i - 25) * 3);
        e.aac = (i != 0);
        exp_q.push_back(e);
      end
      tick();
    end
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    repeat (2) tick();

    do_row(1, 0, 0, 1'b0, 1'b1);
    tick();
    do_row(2, 0, 0, 1'b0, 1'b0);
    tick();
    do_row(3, 0, 0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      do_row(0, 30, 0, 1'b0, 1'b0);
      tick();
    end
    do_row(0, 0, 0, 1'b1, 1'b0);
    do_row(0, 10, 0, 1'b0, 1'b0);
    tick();
    do_row(0, 0, 17, 1'b0, 1'b0);
    tick();
    do_row(1, 0, 0, 1'b0, 1'b0);
    repeat (4) tick();

    check("exp_q_drained", exp_q.size(), 0);
    check("row_q_drained", row_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
